prog_mem: RTL and testbench

Instruction-side program memory that responds to the fetch stage's address/read-data interface. It returns one 32-bit instruction per cycle with a registered read, so data for an address presented in cycle N is valid in cycle N+1. It also contains a byte-stream loader FSM. The loader assembles incoming bytes little-endian into words and writes them sequentially from word 0. It sits between the core fetch port and the boot/UART loader.

---
 rtl/prog_mem.sv | 191 +++++++++++++++++++
 tb/tb_prog_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem -- instruction-side program memory with a byte-stream loader.
//
// The fetch port returns one 32-bit word per cycle through a registered read,
// so data for the address presented in cycle N appears in cycle N+1. While a
// load is in progress the read register returns a NOP (32'h0000_0013).
//
// The loader takes a byte stream, packs it little-endian into words, and
// writes the words sequentially from word 0. The final byte is marked with
// load_last_i. If the stream runs past the end of the array, the load stops
// and load_err_o is set.
//
// Optional feature (compile-time macro):
//   PMEM_CHECKSUM_EN  when defined, checksum_o is the mod-2^32 sum of every
//                     word written during the current load. When undefined,
//                     checksum_o is tied to zero.
//
// Parameters:
//   DEPTH_LOG2           log2 of the number of 32-bit words
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instruction_addr_i   fetch byte address (word index = [DEPTH_LOG2+1:2])
//   instruction_rdata_o  registered instruction word
//   load_start_i         starts a load (honoured only when idle)
//   load_valid_i         load_byte_i is valid this cycle
//   load_byte_i          loader data byte
//   load_last_i          final byte of the image (qualified by load_valid_i)
//   load_ready_o         loader accepts a byte this cycle
//   busy_o               load in progress
//   load_done_o          one-cycle completion pulse
//   load_err_o           sticky overflow flag, cleared by the next start
//   checksum_o           running sum of written words
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module prog_mem #(
  parameter int DEPTH_LOG2 = `MEM_ADDR_WIDTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [`MEM_ADDR_WIDTH-1:0] instruction_addr_i,
  output logic [`DATA_WIDTH-1:0]     instruction_rdata_o,
  input  logic                       load_start_i,
  input  logic                       load_valid_i,
  input  logic [7:0]                 load_byte_i,
  input  logic                       load_last_i,
  output logic                       load_ready_o,
  output logic                       busy_o,
  output logic                       load_done_o,
  output logic                       load_err_o,
  output logic [31:0]                checksum_o
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic [1:0]            cnt_q;
  logic [23:0]           held_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  wr_en;
  logic                  at_last_word;
  logic                  overflow;
  logic [31:0]           wdata;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // Byte-offset bits and address bits above the array are not decoded.
  logic unused_addr;
  assign unused_addr = ^instruction_addr_i;

  assign rd_idx       = instruction_addr_i[DEPTH_LOG2+1:2];
  assign accept       = (state_q == LOAD) && load_valid_i;
  assign wr_en        = accept && ((cnt_q == 2'd3) || load_last_i);
  assign at_last_word = &ptr_q;
  // Filling the top word without the last flag means the image does not fit.
  assign overflow     = wr_en && at_last_word && !load_last_i;

  // Held bytes plus the incoming byte; bytes not yet received read as zero.
  always_comb begin
    wdata = 32'h0;
    unique case (cnt_q)
      2'd0: wdata = {24'h0, load_byte_i};
      2'd1: wdata = {16'h0, load_byte_i, held_q[7:0]};
      2'd2: wdata = {8'h0,  load_byte_i, held_q[15:0]};
      2'd3: wdata = {load_byte_i, held_q[23:0]};
      default: wdata = 32'h0;
    endcase
  end

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load_start_i) state_d = LOAD;
      LOAD: if ((accept && load_last_i) || overflow) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= 2'd0;
      held_q  <= 24'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && load_start_i) begin
        ptr_q  <= '0;
        cnt_q  <= 2'd0;
        held_q <= 24'h0;
        err_q  <= 1'b0;
      end else if (accept) begin
        if (wr_en) begin
          cnt_q  <= 2'd0;
          held_q <= 24'h0;
          // Saturate at the top word: the pointer never wraps.
          if (!at_last_word) ptr_q <= ptr_q + 1'b1;
          if (overflow) err_q <= 1'b1;
        end else begin
          cnt_q                 <= cnt_q + 2'd1;
          held_q[cnt_q*8 +: 8]  <= load_byte_i;
        end
      end
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents
  // across rst_n; only the control state above is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= wdata;
  end

  // A write lands on the edge before the next read sample, so a word read in
  // the cycle after its write already returns the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= NOP;
    end else if (state_q != IDLE) begin
      rdata_q <= NOP;
    end else begin
      rdata_q <= mem[rd_idx];
    end
  end

`ifdef PMEM_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= 32'h0;
    end else if (state_q == IDLE && load_start_i) begin
      checksum_q <= 32'h0;
    end else if (wr_en) begin
      checksum_q <= checksum_q + wdata;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'h0;
`endif

  assign instruction_rdata_o = rdata_q;
  assign load_ready_o        = (state_q == LOAD);
  assign busy_o              = (state_q != IDLE);
  assign load_done_o         = (state_q == DONE);
  assign load_err_o          = err_q;

endmodule

// File: tb/tb_prog_mem.sv
// ---------------------------------------------------------------------------
// tb_prog_mem -- self-checking bench for prog_mem (DEPTH_LOG2 = 2, 4 words).
// A byte-level model packs each image into words, predicts which bytes are
// accepted, the error flag, the checksum and the resulting array contents.
// ---------------------------------------------------------------------------
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_prog_mem;

  localparam int          DL2   = 2;
  localparam int          WORDS = 1 << DL2;
  localparam int          CAP   = WORDS * 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [`MEM_ADDR_WIDTH-1:0] addr;
  logic [`DATA_WIDTH-1:0]     rdata;
  logic                       start, valid, last;
  logic [7:0]                 bdata;
  logic                       ready, busy, done, err;
  logic [31:0]                csum;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [WORDS];
  bit          model_ok  [WORDS];
  logic [7:0]  lb [$];

  prog_mem #(.DEPTH_LOG2(DL2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_addr_i  (addr),
    .instruction_rdata_o (rdata),
    .load_start_i        (start),
    .load_valid_i        (valid),
    .load_byte_i         (bdata),
    .load_last_i         (last),
    .load_ready_o        (ready),
    .busy_o              (busy),
    .load_done_o         (done),
    .load_err_o          (err),
    .checksum_o          (csum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [`MEM_ADDR_WIDTH-1:0] word_addr(input int k);
    logic [`MEM_ADDR_WIDTH-1:0] a;
    a      = $urandom;
    a[3:2] = k[1:0];
    return a;
  endfunction

  // Expected checksum under the current build configuration.
  function automatic logic [31:0] exp_csum(input logic [31:0] sum);
`ifdef PMEM_CHECKSUM_EN
    return sum;
`else
    return 32'h0 & sum;
`endif
  endfunction

  // Loads the image in lb. has_last marks the final byte of lb with last;
  // without it the image must be long enough to overflow.
  task automatic run_load(input bit has_last, input bit gaps);
    int          n, eff, nw;
    bit          exp_err, first;
    logic [31:0] w, sum;
    n       = lb.size();
    eff     = (has_last && n <= CAP) ? n : CAP;
    exp_err = !(has_last && n <= CAP);
    nw      = (eff + 3) / 4;
    sum     = 32'h0;
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < eff) w[8*b +: 8] = lb[4*k + b];
      model_mem[k] = w;
      model_ok[k]  = 1'b1;
      sum          = sum + w;
    end

    @(negedge clk);
    start = 1'b1;
    addr  = $urandom;
    @(negedge clk);
    start = 1'b0;
    first = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && i < eff && ($urandom % 3 == 0)) begin
        check("gap_ready", ready, 1'b1);
        check("gap_done", done, 1'b0);
        check("gap_nop", rdata, NOP);
        valid = 1'b0;
        last  = 1'b0;
        start = $urandom % 2;   // must be ignored inside LOAD
        addr  = $urandom;
        @(negedge clk);
        start = 1'b0;
      end
      check("byte_ready", ready, (i < eff));
      check("byte_done", done, (i == eff));
      if (!first && i <= eff) check("load_nop", rdata, NOP);
      valid = 1'b1;
      bdata = lb[i];
      last  = has_last && (i == n - 1);
      addr  = $urandom;
      @(negedge clk);
      first = 1'b0;
    end
    valid = 1'b0;
    last  = 1'b0;
    if (n == eff) begin
      check("done_pulse", done, 1'b1);
      check("done_ready", ready, 1'b0);
      check("done_busy", busy, 1'b1);
      check("done_nop", rdata, NOP);
      @(negedge clk);
    end
    check("end_busy", busy, 1'b0);
    check("end_done", done, 1'b0);
    check("end_err", err, exp_err);
    check("end_csum", csum, exp_csum(sum));
  endtask

  // Back-to-back fetch of every word, one address per cycle.
  task automatic read_all();
    addr = word_addr(0);
    @(negedge clk);
    for (int k = 0; k < WORDS; k++) begin
      if (model_ok[k]) check($sformatf("fetch_w%0d", k), rdata, model_mem[k]);
      if (k < WORDS - 1) begin
        addr = word_addr(k + 1);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int n;
    bit hl;
    for (int k = 0; k < WORDS; k++) model_ok[k] = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    bdata = 8'h0;
    addr  = $urandom;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, NOP);
    check("rst_ready", ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_csum", csum, 32'h0);
    rst_n = 1'b1;

    // Full single-word image.
    lb = '{8'h13, 8'h00, 8'h50, 8'h00};
    run_load(1'b1, 1'b0);
    addr = word_addr(0);
    @(negedge clk);
    check("fullword_fetch", rdata, 32'h0050_0013);
    check("fullword_csum", csum, exp_csum(32'h0050_0013));

    // Partial last word.
    lb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(1'b1, 1'b0);
    addr = word_addr(0);
    @(negedge clk);
    addr = word_addr(1);
    check("partial_w0", rdata, 32'h0403_0201);
    @(negedge clk);
    check("partial_w1", rdata, 32'h0000_0605);

    // Overflow: 17 bytes, no last flag.
    lb = {};
    for (int i = 0; i < CAP + 1; i++) lb.push_back(8'(8'h20 + i));
    run_load(1'b0, 1'b0);
    read_all();

    // Reset in the middle of a load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      bdata = $urandom;
      @(negedge clk);
    end
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdata", rdata, NOP);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", ready, 1'b0);
    check("midrst_csum", csum, 32'h0);
    read_all();

    // Randomised images, some preceded by stray bytes while idle.
    for (int t = 0; t < 12; t++) begin
      n  = $urandom_range(1, CAP + 4);
      hl = (n < CAP) ? 1'b1 : 1'($urandom % 2);
      if ($urandom % 2 == 0) begin
        @(negedge clk);
        valid = 1'b1;
        bdata = $urandom;
        last  = $urandom % 2;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        check("idle_ready", ready, 1'b0);
        check("idle_busy", busy, 1'b0);
      end
      lb = {};
      for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
      run_load(hl, 1'b1);
      read_all();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
